// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple dual-port RAM with byte write enables and 1/2-cycle registered read
// General-purpose on-chip buffer primitive: one write port, one read port, one clock.
module sdp_ram_be #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int BYTE_WIDTH   = 8,
  parameter  int DEPTH        = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int RDW_MODE     = 0,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [NUM_BYTES-1:0]  wea,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  reb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid
);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $fatal(1, "sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sdp_ram_be: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $fatal(1, "sdp_ram_be: RDW_MODE must be 0 or 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sdp_ram_be: DEPTH must be at least 2");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s1_valid;

  // Out-of-range addresses are dropped rather than aliased onto low words.
  assign w_wr_ok = rst_n && ({1'b0, addra} < DEPTH_W);
  assign w_rd_ok = {1'b0, addrb} < DEPTH_W;

  // Array is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wea[i]) begin
          r_mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_ok) begin
      w_rd_data = r_mem[addrb];
      if (RDW_MODE == 1 && addra == addrb) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wea[i]) begin
            w_rd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= reb;
      if (reb) begin
        r_s1_data <= w_rd_data;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_valid;

    // Data only advances on a valid beat so doutb holds across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign doutb       = r_s2_data;
    assign doutb_valid = r_s2_valid;
  end else begin : g_lat1
    assign doutb       = r_s1_data;
    assign doutb_valid = r_s1_valid;
  end

endmodule
